// File: rtl/alu_unit_if.sv
// rtl/alu_unit_if.sv - issue and result bus between reservation station, ALU and CDB
//
// Issue side : alu_enable, to_alu_op, to_alu_rs1_value, to_alu_rs2_value, to_alu_imm,
//              to_alu_pc, to_alu_rd_renaming (RS -> ALU), alu_full (ALU -> RS)
// Result side: cdb_grant (CDB -> ALU), alu_broadcast, alu_cbd_value, alu_update_rename,
//              alu_is_jump, alu_jump_taken, alu_jump_target (ALU -> CDB)
interface alu_unit_if;
    logic        alu_enable;
    logic [5:0]  to_alu_op;
    logic [31:0] to_alu_rs1_value;
    logic [31:0] to_alu_rs2_value;
    logic [31:0] to_alu_imm;
    logic [31:0] to_alu_pc;
    logic [3:0]  to_alu_rd_renaming;
    logic        alu_full;

    logic        cdb_grant;
    logic        alu_broadcast;
    logic [31:0] alu_cbd_value;
    logic [3:0]  alu_update_rename;
    logic        alu_is_jump;
    logic        alu_jump_taken;
    logic [31:0] alu_jump_target;

    modport master (
        output alu_enable, to_alu_op, to_alu_rs1_value, to_alu_rs2_value, to_alu_imm,
               to_alu_pc, to_alu_rd_renaming, cdb_grant,
        input  alu_full, alu_broadcast, alu_cbd_value, alu_update_rename, alu_is_jump,
               alu_jump_taken, alu_jump_target
    );

    modport slave (
        input  alu_enable, to_alu_op, to_alu_rs1_value, to_alu_rs2_value, to_alu_imm,
               to_alu_pc, to_alu_rd_renaming, cdb_grant,
        output alu_full, alu_broadcast, alu_cbd_value, alu_update_rename, alu_is_jump,
               alu_jump_taken, alu_jump_target
    );
endinterface

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - integer ALU with a result FIFO feeding the common data bus
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   rdy          global enable; low freezes all state
//   jump_wrong   mispredict flush, empties the result FIFO
//   bus          alu_unit_if.slave: issue inputs, alu_full, cdb_grant and head result outputs
//   alu_overflow sticky flag, set when an issue had to be dropped
//
// Opcode table:
//   0 NOP  1 ADD  2 SUB  3 AND  4 OR   5 XOR  6 SLL  7 SRL  8 SRA  9 SLT  10 SLTU
//   11 ADDI 12 ANDI 13 ORI 14 XORI 15 SLLI 16 SRLI 17 SRAI 18 SLTI 19 SLTIU
//   20 LUI 21 AUIPC 22 JAL 23 JALR 24 BEQ 25 BNE 26 BLT 27 BGE 28 BLTU 29 BGEU
//   anything else is undefined and yields an all-zero result
module alu_unit #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    input  logic       jump_wrong,
    alu_unit_if.slave  bus,
    output logic       alu_overflow
);
    localparam logic [5:0] OP_ADD   = 6'd1;
    localparam logic [5:0] OP_SUB   = 6'd2;
    localparam logic [5:0] OP_AND   = 6'd3;
    localparam logic [5:0] OP_OR    = 6'd4;
    localparam logic [5:0] OP_XOR   = 6'd5;
    localparam logic [5:0] OP_SLL   = 6'd6;
    localparam logic [5:0] OP_SRL   = 6'd7;
    localparam logic [5:0] OP_SRA   = 6'd8;
    localparam logic [5:0] OP_SLT   = 6'd9;
    localparam logic [5:0] OP_SLTU  = 6'd10;
    localparam logic [5:0] OP_ADDI  = 6'd11;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_SLLI  = 6'd15;
    localparam logic [5:0] OP_SRLI  = 6'd16;
    localparam logic [5:0] OP_SRAI  = 6'd17;
    localparam logic [5:0] OP_SLTI  = 6'd18;
    localparam logic [5:0] OP_SLTIU = 6'd19;
    localparam logic [5:0] OP_LUI   = 6'd20;
    localparam logic [5:0] OP_AUIPC = 6'd21;
    localparam logic [5:0] OP_JAL   = 6'd22;
    localparam logic [5:0] OP_JALR  = 6'd23;
    localparam logic [5:0] OP_BEQ   = 6'd24;
    localparam logic [5:0] OP_BNE   = 6'd25;
    localparam logic [5:0] OP_BLT   = 6'd26;
    localparam logic [5:0] OP_BGE   = 6'd27;
    localparam logic [5:0] OP_BLTU  = 6'd28;
    localparam logic [5:0] OP_BGEU  = 6'd29;

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    // alu_full is raised one entry early because the RS issue register lags by a cycle
    localparam logic [CW-1:0] FULL_MARK = CW'(FIFO_DEPTH - 1);

    typedef struct packed {
        logic [31:0] value;
        logic [3:0]  rename;
        logic        is_jump;
        logic        taken;
        logic [31:0] target;
    } entry_t;

    entry_t          mem [FIFO_DEPTH];
    logic [PW-1:0]   head_ptr;
    logic [PW-1:0]   tail_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            full_q;
    logic            overflow_q;

    logic            not_empty;
    logic            flush;
    logic            pop;
    logic            push;
    logic            drop;
    entry_t          result;
    entry_t          head;

    // ---------------- combinational execute ----------------
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] branch_target;

    assign rs1           = bus.to_alu_rs1_value;
    assign rs2           = bus.to_alu_rs2_value;
    assign imm           = bus.to_alu_imm;
    assign pc            = bus.to_alu_pc;
    assign branch_target = pc + imm;

    always_comb begin
        result         = '0;
        result.rename  = bus.to_alu_rd_renaming;
        case (bus.to_alu_op)
            OP_ADD:   result.value = rs1 + rs2;
            OP_SUB:   result.value = rs1 - rs2;
            OP_AND:   result.value = rs1 & rs2;
            OP_OR:    result.value = rs1 | rs2;
            OP_XOR:   result.value = rs1 ^ rs2;
            OP_SLL:   result.value = rs1 << rs2[4:0];
            OP_SRL:   result.value = rs1 >> rs2[4:0];
            OP_SRA:   result.value = $signed(rs1) >>> rs2[4:0];
            OP_SLT:   result.value = {31'd0, $signed(rs1) < $signed(rs2)};
            OP_SLTU:  result.value = {31'd0, rs1 < rs2};
            OP_ADDI:  result.value = rs1 + imm;
            OP_ANDI:  result.value = rs1 & imm;
            OP_ORI:   result.value = rs1 | imm;
            OP_XORI:  result.value = rs1 ^ imm;
            OP_SLLI:  result.value = rs1 << imm[4:0];
            OP_SRLI:  result.value = rs1 >> imm[4:0];
            OP_SRAI:  result.value = $signed(rs1) >>> imm[4:0];
            OP_SLTI:  result.value = {31'd0, $signed(rs1) < $signed(imm)};
            OP_SLTIU: result.value = {31'd0, rs1 < imm};
            OP_LUI:   result.value = imm;
            OP_AUIPC: result.value = branch_target;
            OP_JAL: begin
                result.value   = pc + 32'd4;
                result.is_jump = 1'b1;
                result.taken   = 1'b1;
                result.target  = branch_target;
            end
            OP_JALR: begin
                result.value   = pc + 32'd4;
                result.is_jump = 1'b1;
                result.taken   = 1'b1;
                result.target  = (rs1 + imm) & ~32'd1;
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                result.is_jump = 1'b1;
                result.target  = branch_target;
                case (bus.to_alu_op)
                    OP_BEQ:  result.taken = (rs1 == rs2);
                    OP_BNE:  result.taken = (rs1 != rs2);
                    OP_BLT:  result.taken = ($signed(rs1) < $signed(rs2));
                    OP_BGE:  result.taken = ($signed(rs1) >= $signed(rs2));
                    OP_BLTU: result.taken = (rs1 < rs2);
                    default: result.taken = (rs1 >= rs2);
                endcase
            end
            default: result = '0;
        endcase
    end

    // ---------------- FIFO control ----------------
    assign not_empty = (count != '0);
    assign flush     = rdy && jump_wrong;
    assign pop       = not_empty && rdy && bus.cdb_grant && !jump_wrong;
    // a full FIFO still accepts an issue when the head leaves in the same cycle
    assign push      = rdy && !jump_wrong && bus.alu_enable && ((count < DEPTH_C) || pop);
    assign drop      = rdy && !jump_wrong && bus.alu_enable && !push;

    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_ptr   <= '0;
            tail_ptr   <= '0;
            count      <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else if (rdy) begin
            count  <= count_next;
            full_q <= (count_next >= FULL_MARK);
            if (drop)
                overflow_q <= 1'b1;
            if (flush) begin
                head_ptr <= '0;
                tail_ptr <= '0;
            end else begin
                if (push)
                    tail_ptr <= tail_ptr + 1'b1;
                if (pop)
                    head_ptr <= head_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: the outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push)
            mem[tail_ptr] <= result;
    end

    // ---------------- outputs ----------------
    assign head = not_empty ? mem[head_ptr] : '0;

    assign bus.alu_broadcast     = not_empty && rdy;
    assign bus.alu_cbd_value     = head.value;
    assign bus.alu_update_rename = head.rename;
    assign bus.alu_is_jump       = head.is_jump;
    assign bus.alu_jump_taken    = head.taken;
    assign bus.alu_jump_target   = head.target;
    assign bus.alu_full          = full_q;
    assign alu_overflow          = overflow_q;

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - randomized and directed self-checking bench for alu_unit
module tb_alu_unit;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    logic jump_wrong = 1'b0;
    logic alu_overflow;

    alu_unit_if bus();

    alu_unit #(.FIFO_DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .jump_wrong   (jump_wrong),
        .bus          (bus),
        .alu_overflow (alu_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] value;
        logic [3:0]  rename;
        logic        is_jump;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    int n_checks = 0;
    int n_fail   = 0;

    ent_t q[$];
    bit   m_full = 1'b0;
    bit   m_ovf  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference semantics: I-type ops are the R-type op with imm as second operand.
    function automatic ent_t predict(input logic [5:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [31:0] imm,
                                     input logic [31:0] pc, input logic [3:0] rd);
        ent_t e;
        int base;
        logic [31:0] y;
        e = '0;
        e.rename = rd;
        base = op;
        y = b;
        if (op >= 11 && op <= 19) begin
            y = imm;
            case (op)
                11: base = 1;  12: base = 3;  13: base = 4;  14: base = 5;
                15: base = 6;  16: base = 7;  17: base = 8;  18: base = 9;
                default: base = 10;
            endcase
        end
        case (base)
            1:  e.value = a + y;
            2:  e.value = a - y;
            3:  e.value = a & y;
            4:  e.value = a | y;
            5:  e.value = a ^ y;
            6:  e.value = a << (y % 32);
            7:  e.value = a >> (y % 32);
            8:  e.value = 32'($signed(a) >>> (y % 32));
            9:  e.value = (int'(a) < int'(y)) ? 1 : 0;
            10: e.value = (a < y) ? 1 : 0;
            20: e.value = imm;
            21: e.value = pc + imm;
            22, 23: begin
                e.value = pc + 4;
                e.is_jump = 1;
                e.taken = 1;
                e.target = (base == 22) ? pc + imm : ((a + imm) / 2) * 2;
            end
            24, 25, 26, 27, 28, 29: begin
                e.is_jump = 1;
                e.target = pc + imm;
                case (base)
                    24: e.taken = (a == b);
                    25: e.taken = (a != b);
                    26: e.taken = (int'(a) < int'(b));
                    27: e.taken = !(int'(a) < int'(b));
                    28: e.taken = (a < b);
                    default: e.taken = !(a < b);
                endcase
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    // Behavioural model of the result queue.
    always @(posedge clk or negedge rst) begin
        bit do_pop;
        bit room;
        if (!rst) begin
            q.delete();
            m_full = 0;
            m_ovf  = 0;
        end else if (rdy) begin
            if (jump_wrong) begin
                q.delete();
                m_full = 0;
            end else begin
                do_pop = (q.size() != 0) && bus.cdb_grant;
                room   = (q.size() < D) || do_pop;
                if (bus.alu_enable && !room)
                    m_ovf = 1;
                if (do_pop)
                    void'(q.pop_front());
                if (bus.alu_enable && room)
                    q.push_back(predict(bus.to_alu_op, bus.to_alu_rs1_value, bus.to_alu_rs2_value,
                                        bus.to_alu_imm, bus.to_alu_pc, bus.to_alu_rd_renaming));
                m_full = (q.size() >= D - 1);
            end
        end
    end

    // Compare process: outputs against the model every cycle out of reset.
    always @(negedge clk) begin
        ent_t e;
        if (rst === 1'b1) begin
            e = (q.size() != 0) ? q[0] : '0;
            chk("broadcast", 32'(bus.alu_broadcast), 32'((q.size() != 0) && rdy));
            chk("value",     bus.alu_cbd_value,      e.value);
            chk("rename",    32'(bus.alu_update_rename), 32'(e.rename));
            chk("is_jump",   32'(bus.alu_is_jump),   32'(e.is_jump));
            chk("taken",     32'(bus.alu_jump_taken), 32'(e.taken));
            chk("target",    bus.alu_jump_target,    e.target);
            chk("full",      32'(bus.alu_full),      32'(m_full));
            chk("overflow",  32'(alu_overflow),      32'(m_ovf));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [3:0] rd);
        bus.alu_enable         = en;
        bus.to_alu_op          = op;
        bus.to_alu_rs1_value   = a;
        bus.to_alu_rs2_value   = b;
        bus.to_alu_imm         = imm;
        bus.to_alu_pc          = pc;
        bus.to_alu_rd_renaming = rd;
    endtask

    task automatic idle();
        drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic random_phase(input int cycles, input int grant_pct);
        for (int i = 0; i < cycles; i++) begin
            rdy            = ($urandom_range(0, 7) != 0);
            jump_wrong     = ($urandom_range(0, 19) == 0);
            bus.cdb_grant  = ($urandom_range(0, 99) < grant_pct);
            drive(($urandom_range(0, 2) != 0), 6'($urandom_range(0, 31)), rand_operand(),
                  rand_operand(), rand_operand(), $urandom, 4'($urandom));
            step();
        end
        rdy = 1'b1;
        jump_wrong = 1'b0;
        idle();
    endtask

    initial begin
        idle();
        bus.cdb_grant = 1'b0;
        #1;
        // reset state while rst is held low
        chk("rst_broadcast", 32'(bus.alu_broadcast), 32'd0);
        chk("rst_full",      32'(bus.alu_full),      32'd0);
        chk("rst_overflow",  32'(alu_overflow),      32'd0);
        chk("rst_value",     bus.alu_cbd_value,      32'd0);
        step();
        rst = 1'b1;

        // ADD overflow wrap, latency 1, popped on the following edge
        bus.cdb_grant = 1'b1;
        drive(1'b1, 6'd1, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 4'd3);
        step();
        idle();
        chk("add_broadcast", 32'(bus.alu_broadcast), 32'd1);
        chk("add_value",     bus.alu_cbd_value,      32'h8000_0000);
        chk("add_rename",    32'(bus.alu_update_rename), 32'd3);
        step();
        chk("add_popped",    32'(bus.alu_broadcast), 32'd0);

        // BLT signed taken, then BLTU with the same operands not taken
        drive(1'b1, 6'd26, 32'hFFFF_FFFF, 32'd0, 32'h20, 32'h100, 4'd1);
        step();
        chk("blt_is_jump", 32'(bus.alu_is_jump),    32'd1);
        chk("blt_taken",   32'(bus.alu_jump_taken), 32'd1);
        chk("blt_target",  bus.alu_jump_target,     32'h120);
        drive(1'b1, 6'd28, 32'hFFFF_FFFF, 32'd0, 32'h20, 32'h100, 4'd2);
        step();
        chk("bltu_taken",  32'(bus.alu_jump_taken), 32'd0);
        chk("bltu_target", bus.alu_jump_target,     32'h120);

        // JALR clears bit 0 of the target
        drive(1'b1, 6'd23, 32'h1003, 32'd0, 32'd4, 32'h200, 4'd5);
        step();
        idle();
        chk("jalr_value",  bus.alu_cbd_value,       32'h204);
        chk("jalr_target", bus.alu_jump_target,     32'h1006);
        chk("jalr_taken",  32'(bus.alu_jump_taken), 32'd1);
        step();

        // Fill with no grant: early full, fifth issue dropped, four pop in order
        bus.cdb_grant = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 6'd1, 32'(k * 16), 32'd0, 32'd0, 32'd0, 4'(k));
            step();
            chk($sformatf("fill_full_%0d", k), 32'(bus.alu_full), (k >= 3) ? 32'd1 : 32'd0);
        end
        idle();
        chk("fill_overflow", 32'(alu_overflow), 32'd1);
        bus.cdb_grant = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("drain_rename_%0d", k), 32'(bus.alu_update_rename), 32'(k));
            chk($sformatf("drain_value_%0d", k),  bus.alu_cbd_value,          32'(k * 16));
            step();
        end
        chk("drain_empty", 32'(bus.alu_broadcast), 32'd0);
        chk("drain_full",  32'(bus.alu_full),      32'd0);

        // Mispredict flush with a concurrent issue
        do_reset();
        bus.cdb_grant = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            drive(1'b1, 6'd20, 32'd0, 32'd0, 32'(k + 100), 32'd0, 4'(k));
            step();
        end
        jump_wrong = 1'b1;
        drive(1'b1, 6'd20, 32'd0, 32'd0, 32'd999, 32'd0, 4'd9);
        step();
        jump_wrong = 1'b0;
        idle();
        chk("flush_broadcast", 32'(bus.alu_broadcast), 32'd0);
        chk("flush_full",      32'(bus.alu_full),      32'd0);
        step();
        chk("flush_no_issue",  32'(bus.alu_broadcast), 32'd0);

        // Asynchronous reset mid-cycle with three entries buffered
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 6'd20, 32'd0, 32'd0, 32'h5A5A_0000 + 32'(k), 32'd0, 4'(k + 4));
            step();
        end
        idle();
        chk("pre_rst_value", bus.alu_cbd_value, 32'h5A5A_0001);
        #2 rst = 1'b0;
        #1;
        chk("async_broadcast", 32'(bus.alu_broadcast),     32'd0);
        chk("async_value",     bus.alu_cbd_value,          32'd0);
        chk("async_rename",    32'(bus.alu_update_rename), 32'd0);
        chk("async_full",      32'(bus.alu_full),          32'd0);
        step();
        rst = 1'b1;

        // rdy low freezes a granted entry
        drive(1'b1, 6'd21, 32'd0, 32'd0, 32'h10, 32'h4000, 4'd7);
        step();
        idle();
        rdy = 1'b0;
        bus.cdb_grant = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("frozen_broadcast", 32'(bus.alu_broadcast), 32'd0);
        end
        rdy = 1'b1;
        #1;
        chk("thaw_broadcast", 32'(bus.alu_broadcast), 32'd1);
        chk("thaw_value",     bus.alu_cbd_value,      32'h4010);
        step();
        chk("thaw_popped",    32'(bus.alu_broadcast), 32'd0);

        // Randomized traffic against the model
        random_phase(400, 50);
        do_reset();
        random_phase(400, 85);
        do_reset();
        random_phase(200, 20);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
